// File: rtl/shift_ring.sv
// shift_ring: parameterised shift / rotate / parallel-load register ring.
// The ring holds DEPTH stages of WIDTH bits each, with stage k in slice k.
// fill_o counts how many stages hold valid data. A shift adds one to the
// count, stopping at DEPTH. A load sets the count to DEPTH. A clear resets
// the count to 0.
// Optional build macro SHIFT_RING_DIR_EN adds the dir_i port.
//   dir_i = 0 moves data upward (stage k-1 into stage k); serial out is the top stage.
//   dir_i = 1 moves data downward (stage k+1 into stage k); serial out is stage 0.
// Without the macro the ring moves upward only.
module shift_ring #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter logic [WIDTH*DEPTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clr_i,
  input  logic [1:0]                   mode_i,
`ifdef SHIFT_RING_DIR_EN
  input  logic                         dir_i,
`endif
  input  logic [WIDTH-1:0]             data_i,
  input  logic [WIDTH*DEPTH-1:0]       pdata_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [WIDTH*DEPTH-1:0]       pdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o,
  output logic                         full_o
);

  localparam int TOTAL  = WIDTH * DEPTH;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  generate
    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
      $error("shift_ring: DEPTH must be within 2..64");
    end
  endgenerate

  logic [TOTAL-1:0]  ring;
  logic [TOTAL-1:0]  ring_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              down;

`ifdef SHIFT_RING_DIR_EN
  assign down = dir_i;
`else
  assign down = 1'b0;
`endif

  // Next ring contents and fill count. A clear takes priority over every mode.
  always_comb begin
    ring_nxt = ring;
    fill_nxt = fill;
    if (clr_i) begin
      ring_nxt = RESET_VAL;
      fill_nxt = '0;
    end else begin
      case (mode_i)
        MODE_SHIFT: begin
          if (down) ring_nxt = {data_i, ring[TOTAL-1:WIDTH]};
          else      ring_nxt = {ring[TOTAL-WIDTH-1:0], data_i};
          if (fill != FILL_MAX) fill_nxt = fill + 1'b1;
        end
        MODE_ROTATE: begin
          if (down) ring_nxt = {ring[WIDTH-1:0], ring[TOTAL-1:WIDTH]};
          else      ring_nxt = {ring[TOTAL-WIDTH-1:0], ring[TOTAL-1 -: WIDTH]};
        end
        MODE_LOAD: begin
          ring_nxt = pdata_i;
          fill_nxt = FILL_MAX;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // State register. The asynchronous reset restores the per-stage reset pattern and empties the fill count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ring <= RESET_VAL;
      fill <= '0;
    end else begin
      ring <= ring_nxt;
      fill <= fill_nxt;
    end
  end

  // Outputs come from registers only. The serial output follows the end stage for the current direction.
  assign pdata_o = ring;
  assign data_o  = down ? ring[WIDTH-1:0] : ring[TOTAL-1 -: WIDTH];
  assign fill_o  = fill;
  assign full_o  = (fill == FILL_MAX);

endmodule

// File: doc/shift_ring.md
SHIFT_RING -- requirements
Module: shift_ring

Interface
- REQ-001: Parameter WIDTH, default 1, bit width of one stage.
- REQ-002: Parameter DEPTH, default 8, number of stages; legal range 2..64.
- REQ-003: Parameter RESET_VAL, default 0, WIDTH*DEPTH bits; stage k resets to slice [k*WIDTH +: WIDTH].
- REQ-004: clk_i  input  1  clock; all state updates on rising edge.
- REQ-005: reset_n_i  input  1  reset; asynchronous, active-low.
- REQ-006: clr_i  input  1  synchronous clear.
- REQ-007: mode_i  input  2  operation: 00 hold, 01 shift, 10 rotate, 11 parallel load.
- REQ-008: data_i  input  WIDTH  serial input for shift.
- REQ-009: pdata_i  input  WIDTH*DEPTH  parallel load data; stage k = slice k.
- REQ-010: data_o  output  WIDTH  serial output, equals the end stage (see REQ-016).
- REQ-011: pdata_o  output  WIDTH*DEPTH  all stages, stage k = slice k.
- REQ-012: fill_o  output  clog2(DEPTH+1)  valid stage count.
- REQ-013: full_o  output  1  high when fill_o == DEPTH.

Function
- REQ-014: Priority per cycle: clr_i over mode_i; clr_i sets every stage to its RESET_VAL slice and fill to 0.
- REQ-015: Hold (00): stages and fill unchanged.
- REQ-016: Shift (01), upward: stage 0 <- data_i, stage k <- stage k-1; data_o = stage DEPTH-1 (registered, no combinational path from data_i).
- REQ-017: Rotate (10), upward: stage 0 <- stage DEPTH-1, stage k <- stage k-1; data_i ignored; fill unchanged.
- REQ-018: Load (11): stage k <- pdata_i slice k; fill <- DEPTH.
- REQ-019: Shift increments fill by 1, saturating at DEPTH; no wrap to 0.
- REQ-020: full_o, data_o, pdata_o are combinational decodes of registers only; single-cycle latency from input to pdata_o.
- REQ-021: Serial latency: a value presented on data_i under DEPTH consecutive shift cycles appears on data_o after the DEPTH-th edge.
- REQ-022: Rotate for DEPTH consecutive cycles returns all stages to their original values.

Reset
- REQ-023: reset_n_i low asynchronously forces stage k to RESET_VAL slice k, fill_o to 0, full_o to 0, independent of clk_i.
- REQ-024: Reset asserted mid-shift or mid-rotate discards the operation; first update after deassertion occurs on the first rising edge with reset_n_i high.

Configuration
- REQ-025: Macro SHIFT_RING_DIR_EN, when defined, adds port dir_i (input, 1 bit): 0 = upward as REQ-016/017; 1 = downward, stage DEPTH-1 <- data_i (shift) or stage 0 (rotate), stage k <- stage k+1, and data_o = stage 0.
- REQ-026: Without SHIFT_RING_DIR_EN, port dir_i does not exist and behaviour is upward only; fill rules are identical in both builds.

Verification
- REQ-027: WIDTH=1, DEPTH=8, RESET_VAL=8'b10101010, reset low then high -> pdata_o = 8'hAA, fill_o=0, full_o=0.
- REQ-028: From reset, shift 8 cycles with data_i=1 -> pdata_o=8'hFF, fill_o=8, full_o=1; 9th shift keeps fill_o=8.
- REQ-029: Load pdata_i=8'h81, then rotate 1 cycle -> pdata_o=8'h03; rotate 7 more -> 8'h81, fill_o=8 throughout.
- REQ-030: WIDTH=4, DEPTH=4: load 16'h4321, assert clr_i together with mode_i=11 -> pdata_o=RESET_VAL, fill_o=0.
- REQ-031: Assert reset_n_i low between clock edges during shifting -> outputs reach reset values before next edge; shifting resumes from fill_o=0.
- REQ-032: SHIFT_RING_DIR_EN build, DEPTH=8: load 8'h01, dir_i=1, rotate 1 -> 8'h80, data_o=0; shift data_i=1 with dir_i=1 -> stage 7=1, data_o equals previous stage 1.
